rapid_lsu: RTL and testbench

Load/store unit sitting directly downstream of the decode stage in the RAPID core. It consumes decoded memory operations (control_s.mem, fcs_opcode, rs1/rs2 operand values, rd) and turns them into single-beat data-cache transactions using the shared cache_rw / cache_operation types. It aligns store data and byte strobes, waits for the cache response, then sign- or zero-extends load data for writeback. One operation is in flight at a time; upstream is stalled via a valid/ready handshake.

---
 rtl/rapid_lsu_pkg.sv | 77 +++++++
 rtl/rapid_lsu_align.sv | 44 ++++
 rtl/rapid_lsu.sv | 172 +++++++++++++++++
 tb/tb_rapid_lsu.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapid_lsu_pkg.sv
// Shared types for the RAPID load/store unit: cache request encodings, FSM state
// names, decoded request record and funct3 helpers.
package rapid_lsu_pkg;

   localparam int LSU_XLEN   = 32;
   localparam int WORD_WIDTH = LSU_XLEN / 8;

   typedef enum logic {
      CACHE_READ  = 1'b0,
      CACHE_WRITE = 1'b1
   } cache_rw_e;

   typedef enum logic [1:0] {
      CACHE_NOP = 2'd0,
      BYTE      = 2'd1,
      HALF_WORD = 2'd2,
      WORD      = 2'd3
   } cache_operation;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef struct packed {
      logic                store;
      logic [2:0]          funct3;
      logic [LSU_XLEN-1:0] ea;
      logic [LSU_XLEN-1:0] wdata;
      logic [4:0]          rd;
   } lsu_req_s;

   // Halfword lanes follow ea[1] only, so a misaligned halfword folds onto its
   // naturally aligned lane when the trap is disabled.
   function automatic logic [WORD_WIDTH-1:0] lsu_strobe(input logic [2:0] funct3,
                                                        input logic [1:0] ea_lo);
      logic [WORD_WIDTH-1:0] strb;
      strb = '0;
      case (funct3)
         FUNCT3_B, FUNCT3_BU: strb = 4'b0001 << ea_lo;
         FUNCT3_H, FUNCT3_HU: strb = ea_lo[1] ? 4'b1100 : 4'b0011;
         FUNCT3_W:            strb = 4'b1111;
         default:             strb = '0;
      endcase
      return strb;
   endfunction

   function automatic logic lsu_funct3_legal(input logic store, input logic [2:0] funct3);
      logic legal;
      case (funct3)
         FUNCT3_B, FUNCT3_H, FUNCT3_W: legal = 1'b1;
         FUNCT3_BU, FUNCT3_HU:         legal = !store;
         default:                      legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic cache_operation lsu_funct3_to_op(input logic [2:0] funct3);
      cache_operation op;
      case (funct3)
         FUNCT3_B, FUNCT3_BU: op = BYTE;
         FUNCT3_H, FUNCT3_HU: op = HALF_WORD;
         FUNCT3_W:            op = WORD;
         default:             op = CACHE_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rapid_lsu_align.sv
// Combinational data steering for the LSU: store lane replication and strobes,
// load lane selection with sign or zero extension.
module rapid_lsu_align
   import rapid_lsu_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            ea_lo,
   input  logic [XLEN-1:0]       store_data,
   input  logic [XLEN-1:0]       load_word,
   output logic [XLEN-1:0]       wdata_rep,
   output logic [WORD_WIDTH-1:0] wstrb,
   output logic [XLEN-1:0]       load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign wstrb    = lsu_strobe(funct3, ea_lo);
   assign byte_sel = load_word[{ea_lo, 3'b000} +: 8];
   assign half_sel = ea_lo[1] ? load_word[31:16] : load_word[15:0];

   always_comb begin
      wdata_rep = store_data;
      case (funct3)
         FUNCT3_B: wdata_rep = {(XLEN/8){store_data[7:0]}};
         FUNCT3_H: wdata_rep = {(XLEN/16){store_data[15:0]}};
         default:  wdata_rep = store_data;
      endcase
   end

   always_comb begin
      load_data = load_word;
      case (funct3)
         FUNCT3_B:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         FUNCT3_BU: load_data = {{(XLEN-8){1'b0}}, byte_sel};
         FUNCT3_H:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         FUNCT3_HU: load_data = {{(XLEN-16){1'b0}}, half_sel};
         default:   load_data = load_word;
      endcase
   end

endmodule

// File: rtl/rapid_lsu.sv
// RAPID load/store unit: one decoded memory op at a time, IDLE->REQ->WAIT->DONE.
// Optional misalignment trap enabled by defining RAPID_LSU_MISALIGN_TRAP_EN.
module rapid_lsu
   import rapid_lsu_pkg::*;
#(
   parameter int XLEN         = LSU_XLEN,
   parameter int RESP_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [XLEN-1:0]       req_base,
   input  logic [XLEN-1:0]       req_offset,
   input  logic [XLEN-1:0]       req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  cache_valid,
   input  logic                  cache_ready,
   output cache_rw_e             cache_rw,
   output cache_operation        cache_op,
   output logic [XLEN-1:0]       cache_addr,
   output logic [XLEN-1:0]       cache_wdata,
   output logic [WORD_WIDTH-1:0] cache_wstrb,
   input  logic                  cache_rvalid,
   input  logic [XLEN-1:0]       cache_rdata,
   output logic                  wb_valid,
   output logic                  wb_we,
   output logic [4:0]            wb_rd,
   output logic [XLEN-1:0]       wb_data,
   output logic                  fault,
   output lsu_state_e            dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int         TW     = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

   logic [1:0]            state_q, state_d;
   lsu_req_s              req_q, req_d;
   logic [XLEN-1:0]       rdata_q, rdata_d;
   logic                  fault_q, fault_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [TW-1:0]         timer_inc;
   logic [XLEN-1:0]       ea;
   logic                  bad_op;
   logic                  misalign;
   logic                  in_req;
   logic                  in_done;
   logic [XLEN-1:0]       wdata_rep;
   logic [WORD_WIDTH-1:0] strb;
   logic [XLEN-1:0]       load_data;

   assign ea        = req_base + req_offset;
   assign bad_op    = !lsu_funct3_legal(req_store, req_funct3);
   assign timer_inc = timer_q + TW'(1);
   assign in_req    = (state_q == S_REQ);
   assign in_done   = (state_q == S_DONE);

`ifdef RAPID_LSU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (req_funct3)
         FUNCT3_H, FUNCT3_HU: misalign = ea[0];
         FUNCT3_W:            misalign = |ea[1:0];
         default:             misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // req_valid/req_ready: an op transfers on the edge where both are high;
   // req_ready is high only in IDLE, so a second op waits for the first to retire.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_d.store  = req_store;
               req_d.funct3 = req_funct3;
               req_d.ea     = ea;
               req_d.wdata  = req_wdata;
               req_d.rd     = req_rd;
               rdata_d      = '0;
               timer_d      = '0;
               fault_d      = bad_op || misalign;
               state_d      = (bad_op || misalign) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (cache_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cache_rvalid) begin
               rdata_d = cache_rdata;
               state_d = S_DONE;
            end else if ((RESP_TIMEOUT != 0) && (timer_inc == TW'(RESP_TIMEOUT))) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         timer_q <= timer_d;
      end
   end

   rapid_lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (req_q.funct3),
      .ea_lo      (req_q.ea[1:0]),
      .store_data (req_q.wdata),
      .load_word  (rdata_q),
      .wdata_rep  (wdata_rep),
      .wstrb      (strb),
      .load_data  (load_data)
   );

   // Cache outputs are derived from the latched request, so they hold steady
   // for as long as REQ waits on cache_ready; rst masks the request at once.
   always_comb begin
      cache_valid = in_req && !rst;
      cache_rw    = CACHE_READ;
      cache_op    = CACHE_NOP;
      cache_addr  = '0;
      cache_wdata = '0;
      cache_wstrb = '0;
      if (in_req) begin
         cache_rw    = req_q.store ? CACHE_WRITE : CACHE_READ;
         cache_op    = lsu_funct3_to_op(req_q.funct3);
         cache_addr  = {req_q.ea[XLEN-1:2], 2'b00};
         cache_wdata = req_q.store ? wdata_rep : '0;
         cache_wstrb = strb;
      end
   end

   always_comb begin
      wb_valid = in_done;
      fault    = in_done && fault_q;
      wb_we    = in_done && !fault_q && !req_q.store && (req_q.rd != 5'd0);
      wb_rd    = in_done ? req_q.rd : 5'd0;
      wb_data  = (in_done && !fault_q && !req_q.store) ? load_data : '0;
   end

   assign req_ready = (state_q == S_IDLE);
   assign dbg_state = lsu_state_e'(state_q);

endmodule

// File: tb/tb_rapid_lsu.sv
// Directed bench for rapid_lsu: a cache responder driven per op with
// configurable ready/response delays, checks inline in each scenario task.
`timescale 1ns/1ps
module tb_rapid_lsu;
   import rapid_lsu_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_store = 1'b0;
   logic [2:0]     req_funct3 = 3'b000;
   logic [31:0]    req_base = '0;
   logic [31:0]    req_offset = '0;
   logic [31:0]    req_wdata = '0;
   logic [4:0]     req_rd = '0;
   logic           cache_valid;
   logic           cache_ready = 1'b0;
   cache_rw_e      cache_rw;
   cache_operation cache_op;
   logic [31:0]    cache_addr;
   logic [31:0]    cache_wdata;
   logic [3:0]     cache_wstrb;
   logic           cache_rvalid = 1'b0;
   logic [31:0]    cache_rdata = '0;
   logic           wb_valid;
   logic           wb_we;
   logic [4:0]     wb_rd;
   logic [31:0]    wb_data;
   logic           fault;
   lsu_state_e     dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   // Values captured by run_op for the calling scenario to check.
   logic           r_saw_cv, r_unstable, r_ready_bad, r_acc_ready, r_wb_seen, r_pulse_ok;
   logic           r_we, r_fault;
   logic [31:0]    r_addr, r_wdata, r_data;
   logic [3:0]     r_strb;
   logic [4:0]     r_rd;
   cache_rw_e      r_rw;
   cache_operation r_op;
   int             r_lat, r_cv_cycles;

   rapid_lsu #(.XLEN(32), .RESP_TIMEOUT(255)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_store    (req_store),
      .req_funct3   (req_funct3),
      .req_base     (req_base),
      .req_offset   (req_offset),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .cache_valid  (cache_valid),
      .cache_ready  (cache_ready),
      .cache_rw     (cache_rw),
      .cache_op     (cache_op),
      .cache_addr   (cache_addr),
      .cache_wdata  (cache_wdata),
      .cache_wstrb  (cache_wstrb),
      .cache_rvalid (cache_rvalid),
      .cache_rdata  (cache_rdata),
      .wb_valid     (wb_valid),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .fault        (fault),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   // Driver: issues one op, plays the cache for it and records what it saw.
   task automatic run_op(input logic store, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wdata, input logic [4:0] rd,
                         input int ready_delay, input int rvalid_delay, input logic [31:0] rdata);
      int   cyc;
      int   wait_cnt;
      logic in_wait;
      r_saw_cv = 0; r_unstable = 0; r_ready_bad = 0; r_wb_seen = 0; r_pulse_ok = 0;
      r_we = 0; r_fault = 0; r_data = '0; r_rd = '0; r_addr = '0; r_wdata = '0; r_strb = '0;
      r_rw = CACHE_READ; r_op = CACHE_NOP; r_lat = -1; r_cv_cycles = 0;
      in_wait = 0; wait_cnt = 0;
      @(negedge clk);
      r_acc_ready = req_ready;
      req_valid = 1; req_store = store; req_funct3 = f3; req_base = base;
      req_offset = off; req_wdata = wdata; req_rd = rd;
      @(negedge clk);
      req_valid = 0; req_store = 0; req_funct3 = '0; req_base = '0;
      req_offset = '0; req_wdata = '0; req_rd = '0;
      cyc = 1;
      while (!r_wb_seen && cyc < 400) begin
         if (req_ready) r_ready_bad = 1;
         if (wb_valid) begin
            r_wb_seen = 1; r_lat = cyc; r_we = wb_we; r_data = wb_data;
            r_rd = wb_rd; r_fault = fault;
            cache_rvalid = 0; cache_rdata = '0;
         end else if (in_wait) begin
            cache_rvalid = (wait_cnt >= rvalid_delay);
            cache_rdata  = cache_rvalid ? rdata : '0;
            wait_cnt++;
         end
         if (cache_valid) begin
            if (!r_saw_cv) begin
               r_addr = cache_addr; r_wdata = cache_wdata; r_strb = cache_wstrb;
               r_rw = cache_rw; r_op = cache_op;
            end else if (cache_addr !== r_addr || cache_wdata !== r_wdata ||
                         cache_wstrb !== r_strb || cache_op !== r_op || cache_rw !== r_rw) begin
               r_unstable = 1;
            end
            r_saw_cv = 1;
            cache_ready = (r_cv_cycles >= ready_delay);
            r_cv_cycles++;
            if (cache_ready) in_wait = 1;
         end else begin
            cache_ready = 0;
         end
         @(negedge clk);
         cyc++;
      end
      cache_ready = 0; cache_rvalid = 0; cache_rdata = '0;
      r_pulse_ok = (wb_valid === 1'b0) && (fault === 1'b0) && (req_ready === 1'b1);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 0;
      n_cmp++;
      if (req_ready !== 1'b1 || dbg_state !== IDLE) begin
         n_fail++; $display("FAIL reset_ready: got ready=%b state=%0d, expected ready=1 state=0", req_ready, dbg_state);
      end
      n_cmp++;
      if (cache_valid !== 1'b0 || cache_op !== CACHE_NOP || cache_rw !== CACHE_READ ||
          cache_addr !== 32'h0 || cache_wdata !== 32'h0 || cache_wstrb !== 4'h0) begin
         n_fail++; $display("FAIL reset_cache: got v=%b op=%0d rw=%0d a=%h d=%h s=%b, expected all zero/NOP/READ",
                            cache_valid, cache_op, cache_rw, cache_addr, cache_wdata, cache_wstrb);
      end
      n_cmp++;
      if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0 || fault !== 1'b0) begin
         n_fail++; $display("FAIL reset_wb: got v=%b we=%b rd=%0d d=%h f=%b, expected all zero",
                            wb_valid, wb_we, wb_rd, wb_data, fault);
      end
   endtask

   task automatic test_lw();
      run_op(1'b0, FUNCT3_W, 32'h1000, 32'h4, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF);
      n_cmp++;
      if (r_addr !== 32'h1004 || r_strb !== 4'b1111 || r_op !== WORD || r_rw !== CACHE_READ) begin
         n_fail++; $display("FAIL lw_req: got a=%h s=%b op=%0d rw=%0d, expected a=00001004 s=1111 op=3 rw=0", r_addr, r_strb, r_op, r_rw);
      end
      n_cmp++;
      if (r_lat !== 3) begin
         n_fail++; $display("FAIL lw_latency: got %0d cycles, expected 3", r_lat);
      end
      n_cmp++;
      if (r_data !== 32'hDEADBEEF || r_we !== 1'b1 || r_rd !== 5'd5 || r_fault !== 1'b0) begin
         n_fail++; $display("FAIL lw_wb: got d=%h we=%b rd=%0d f=%b, expected d=deadbeef we=1 rd=5 f=0", r_data, r_we, r_rd, r_fault);
      end
      n_cmp++;
      if (r_pulse_ok !== 1'b1 || r_ready_bad !== 1'b0) begin
         n_fail++; $display("FAIL lw_pulse: got pulse_ok=%b ready_busy=%b, expected 1 and 0", r_pulse_ok, r_ready_bad);
      end
   endtask

   task automatic test_lb_lbu();
      run_op(1'b0, FUNCT3_B, 32'h2000, 32'h3, 32'h0, 5'd6, 0, 0, 32'h80AA5511);
      n_cmp++;
      if (r_addr !== 32'h2000 || r_strb !== 4'b1000 || r_op !== BYTE) begin
         n_fail++; $display("FAIL lb_req: got a=%h s=%b op=%0d, expected a=00002000 s=1000 op=1", r_addr, r_strb, r_op);
      end
      n_cmp++;
      if (r_data !== 32'hFFFFFF80 || r_we !== 1'b1) begin
         n_fail++; $display("FAIL lb_data: got d=%h we=%b, expected d=ffffff80 we=1", r_data, r_we);
      end
      // Negative offset wraps: 0x2004 + (-1) = 0x2003.
      run_op(1'b0, FUNCT3_BU, 32'h2004, 32'hFFFFFFFF, 32'h0, 5'd7, 0, 0, 32'h80AA5511);
      n_cmp++;
      if (r_addr !== 32'h2000 || r_data !== 32'h00000080) begin
         n_fail++; $display("FAIL lbu_data: got a=%h d=%h, expected a=00002000 d=00000080", r_addr, r_data);
      end
   endtask

   task automatic test_sh();
      run_op(1'b1, FUNCT3_H, 32'h3000, 32'h2, 32'h1234ABCD, 5'd9, 0, 2, 32'h0);
      n_cmp++;
      if (r_strb !== 4'b1100 || r_wdata !== 32'hABCDABCD || r_rw !== CACHE_WRITE ||
          r_addr !== 32'h3000 || r_op !== HALF_WORD) begin
         n_fail++; $display("FAIL sh_req: got s=%b d=%h rw=%0d a=%h op=%0d, expected s=1100 d=abcdabcd rw=1 a=00003000 op=2",
                            r_strb, r_wdata, r_rw, r_addr, r_op);
      end
      n_cmp++;
      if (r_wb_seen !== 1'b1 || r_we !== 1'b0 || r_lat !== 5 || r_fault !== 1'b0) begin
         n_fail++; $display("FAIL sh_wb: got seen=%b we=%b lat=%0d f=%b, expected seen=1 we=0 lat=5 f=0", r_wb_seen, r_we, r_lat, r_fault);
      end
   endtask

   task automatic test_stores();
      run_op(1'b1, FUNCT3_B, 32'h6000, 32'h1, 32'h000000A5, 5'd0, 0, 0, 32'h0);
      n_cmp++;
      if (r_strb !== 4'b0010 || r_wdata !== 32'hA5A5A5A5 || r_op !== BYTE || r_rw !== CACHE_WRITE) begin
         n_fail++; $display("FAIL sb_req: got s=%b d=%h op=%0d rw=%0d, expected s=0010 d=a5a5a5a5 op=1 rw=1", r_strb, r_wdata, r_op, r_rw);
      end
      run_op(1'b1, FUNCT3_W, 32'h6000, 32'h0, 32'hCAFEF00D, 5'd4, 0, 0, 32'h0);
      n_cmp++;
      if (r_strb !== 4'b1111 || r_wdata !== 32'hCAFEF00D || r_op !== WORD || r_we !== 1'b0) begin
         n_fail++; $display("FAIL sw_req: got s=%b d=%h op=%0d we=%b, expected s=1111 d=cafef00d op=3 we=0", r_strb, r_wdata, r_op, r_we);
      end
   endtask

   task automatic test_ready_stall();
      run_op(1'b0, FUNCT3_H, 32'h5000, 32'h2, 32'h0, 5'd10, 5, 0, 32'h80017FFF);
      n_cmp++;
      if (r_cv_cycles !== 6 || r_unstable !== 1'b0 || r_ready_bad !== 1'b0) begin
         n_fail++; $display("FAIL stall_hold: got cv_cycles=%0d unstable=%b ready_busy=%b, expected 6 0 0", r_cv_cycles, r_unstable, r_ready_bad);
      end
      n_cmp++;
      if (r_lat !== 8 || r_data !== 32'hFFFF8001 || r_addr !== 32'h5000 || r_strb !== 4'b1100) begin
         n_fail++; $display("FAIL stall_wb: got lat=%0d d=%h a=%h s=%b, expected lat=8 d=ffff8001 a=00005000 s=1100", r_lat, r_data, r_addr, r_strb);
      end
      run_op(1'b0, FUNCT3_HU, 32'h5000, 32'h0, 32'h0, 5'd11, 0, 0, 32'h80017FFF);
      n_cmp++;
      if (r_data !== 32'h00007FFF || r_strb !== 4'b0011) begin
         n_fail++; $display("FAIL lhu_data: got d=%h s=%b, expected d=00007fff s=0011", r_data, r_strb);
      end
   endtask

   task automatic test_rd_zero_illegal();
      run_op(1'b0, FUNCT3_W, 32'h1000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h12345678);
      n_cmp++;
      if (r_wb_seen !== 1'b1 || r_we !== 1'b0 || r_fault !== 1'b0) begin
         n_fail++; $display("FAIL rd0_wb: got seen=%b we=%b f=%b, expected 1 0 0", r_wb_seen, r_we, r_fault);
      end
      run_op(1'b0, 3'b111, 32'h1000, 32'h0, 32'h0, 5'd3, 0, 0, 32'h0);
      n_cmp++;
      if (r_fault !== 1'b1 || r_saw_cv !== 1'b0 || r_we !== 1'b0 || r_lat !== 1 || r_pulse_ok !== 1'b1) begin
         n_fail++; $display("FAIL illegal_f3: got f=%b cv=%b we=%b lat=%0d pulse_ok=%b, expected 1 0 0 1 1",
                            r_fault, r_saw_cv, r_we, r_lat, r_pulse_ok);
      end
      run_op(1'b1, FUNCT3_BU, 32'h1000, 32'h0, 32'hFF, 5'd3, 0, 0, 32'h0);
      n_cmp++;
      if (r_fault !== 1'b1 || r_saw_cv !== 1'b0) begin
         n_fail++; $display("FAIL illegal_store: got f=%b cv=%b, expected f=1 cv=0", r_fault, r_saw_cv);
      end
   endtask

   task automatic test_misalign();
`ifdef RAPID_LSU_MISALIGN_TRAP_EN
      run_op(1'b0, FUNCT3_H, 32'h4000, 32'h1, 32'h0, 5'd8, 0, 0, 32'h1234F00D);
      n_cmp++;
      if (r_fault !== 1'b1 || r_saw_cv !== 1'b0 || r_we !== 1'b0 || r_lat !== 1) begin
         n_fail++; $display("FAIL misalign_trap: got f=%b cv=%b we=%b lat=%0d, expected 1 0 0 1", r_fault, r_saw_cv, r_we, r_lat);
      end
`else
      run_op(1'b0, FUNCT3_H, 32'h4000, 32'h1, 32'h0, 5'd8, 0, 0, 32'h1234F00D);
      n_cmp++;
      if (r_fault !== 1'b0 || r_addr !== 32'h4000 || r_strb !== 4'b0011 || r_data !== 32'hFFFFF00D) begin
         n_fail++; $display("FAIL misalign_trunc: got f=%b a=%h s=%b d=%h, expected f=0 a=00004000 s=0011 d=fffff00d",
                            r_fault, r_addr, r_strb, r_data);
      end
`endif
   endtask

   task automatic test_timeout();
      run_op(1'b0, FUNCT3_W, 32'h8000, 32'h0, 32'h0, 5'd7, 0, 1000, 32'h0);
      n_cmp++;
      if (r_wb_seen !== 1'b1 || r_fault !== 1'b1 || r_we !== 1'b0 || r_lat !== 257 || r_pulse_ok !== 1'b1) begin
         n_fail++; $display("FAIL timeout: got seen=%b f=%b we=%b lat=%0d pulse_ok=%b, expected 1 1 0 257 1",
                            r_wb_seen, r_fault, r_we, r_lat, r_pulse_ok);
      end
   endtask

   task automatic test_back_to_back();
      run_op(1'b1, FUNCT3_B, 32'h6000, 32'h3, 32'h0000005A, 5'd0, 0, 0, 32'h0);
      run_op(1'b0, FUNCT3_W, 32'h6000, 32'h8, 32'h0, 5'd12, 0, 0, 32'h0BADF00D);
      n_cmp++;
      if (r_acc_ready !== 1'b1 || r_addr !== 32'h6008 || r_data !== 32'h0BADF00D || r_lat !== 3) begin
         n_fail++; $display("FAIL b2b_second: got ready=%b a=%h d=%h lat=%0d, expected 1 00006008 0badf00d 3",
                            r_acc_ready, r_addr, r_data, r_lat);
      end
   endtask

   task automatic test_reset_mid_op();
      int wb_bad;
      @(negedge clk);
      req_valid = 1; req_funct3 = FUNCT3_W; req_base = 32'h7000; req_rd = 5'd3;
      @(negedge clk);
      req_valid = 0; req_base = '0; req_rd = '0; req_funct3 = '0;
      cache_ready = 1;
      @(negedge clk);
      cache_ready = 0;
      n_cmp++;
      if (dbg_state !== WAIT) begin
         n_fail++; $display("FAIL rst_setup: got state=%0d, expected 2 (WAIT)", dbg_state);
      end
      rst = 1;
      @(negedge clk);
      rst = 0; cache_rvalid = 1; cache_rdata = 32'h11111111;
      n_cmp++;
      if (req_ready !== 1'b1 || cache_valid !== 1'b0 || cache_op !== CACHE_NOP || cache_addr !== 32'h0 ||
          wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0 || fault !== 1'b0) begin
         n_fail++; $display("FAIL rst_wait_outputs: got ready=%b cv=%b op=%0d a=%h wbv=%b d=%h rd=%0d f=%b, expected reset values",
                            req_ready, cache_valid, cache_op, cache_addr, wb_valid, wb_data, wb_rd, fault);
      end
      wb_bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (wb_valid !== 1'b0 || fault !== 1'b0 || req_ready !== 1'b1) wb_bad++;
      end
      cache_rvalid = 0; cache_rdata = '0;
      n_cmp++;
      if (wb_bad !== 0) begin
         n_fail++; $display("FAIL rst_stale_rvalid: got %0d bad cycles, expected 0", wb_bad);
      end
      // Reset while the request is presented must mask cache_valid in the same cycle.
      req_valid = 1; req_funct3 = FUNCT3_W; req_base = 32'h7100; req_rd = 5'd3;
      @(negedge clk);
      req_valid = 0; req_base = '0; req_rd = '0; req_funct3 = '0;
      n_cmp++;
      if (cache_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_req_setup: got cache_valid=%b, expected 1", cache_valid);
      end
      rst = 1;
      #1;
      n_cmp++;
      if (cache_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_drop_valid: got cache_valid=%b, expected 0", cache_valid);
      end
      @(negedge clk);
      rst = 0;
      n_cmp++;
      if (req_ready !== 1'b1 || dbg_state !== IDLE || cache_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_req_idle: got ready=%b state=%0d cv=%b, expected 1 0 0", req_ready, dbg_state, cache_valid);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_stores();
      test_ready_stall();
      test_rd_zero_illegal();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
